// File: rtl/crc7_encoder.sv
// Bit-serial CRC-7 encoder: takes a data word over valid/ready, shifts it MSB-first
// through a CRC LFSR, then presents {data, crc} until the downstream consumes it.
module crc7_encoder #(
    parameter int                DATA_W = 16,
    parameter int                CRC_W  = 7,
    parameter logic [CRC_W-1:0]  POLY   = 7'h09
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W+CRC_W-1:0]   out_code,
    output logic                      busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shift_reg, hold_data;
    logic [CRC_W-1:0]    crc;
    logic [CNT_W-1:0]    cnt;
    logic                accept, fb;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_code  = '0;
        case (state)
            IDLE: begin
                // gated by reset so nothing advertises readiness while held in reset
                in_ready = reset;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_code  = {hold_data, crc};
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fb = shift_reg[DATA_W-1] ^ crc[CRC_W-1];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            hold_data <= '0;
            crc       <= '0;
            cnt       <= '0;
        end else if (accept) begin
            shift_reg <= in_data;
            hold_data <= in_data;
            crc       <= '0;
            cnt       <= '0;
        end else if (state == SHIFT) begin
            crc       <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            shift_reg <= shift_reg << 1;
            cnt       <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_crc7_encoder.sv
// Self-checking bench for crc7_encoder: directed vector table, stall/reset sequences,
// and random words checked against a polynomial long-division reference.
module tb_crc7_encoder;
    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_code;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    crc7_encoder dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        logic [22:0] code;
    } vec_t;

    vec_t vecs[4];

    // Remainder of a 23-bit polynomial modulo x^7+x^3+1 by plain long division.
    function automatic logic [6:0] poly_mod(input logic [22:0] v);
        logic [22:0] r;
        logic [22:0] g;
        r = v;
        for (int i = 22; i >= 7; i--) begin
            g = 23'h89 << (i - 7);
            if (r[i]) r = r ^ g;
        end
        return r[6:0];
    endfunction

    function automatic logic [22:0] ref_code(input logic [15:0] d);
        return {d, poly_mod({d, 7'b0})};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one word, returns the codeword seen and edges from accept to out_valid.
    task automatic send(input logic [15:0] d, output logic [22:0] code, output int lat);
        int w;
        w = 0;
        @(negedge CLK);
        while (!in_ready && w < 100) begin
            @(negedge CLK);
            w++;
        end
        check("accept_wait", 32'(w < 100), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        code = out_code;
    endtask

    initial begin
        logic [22:0] code, code_a;
        logic [15:0] d, b_word;
        int lat;

        vecs[0] = '{16'h0000, 23'h000000};
        vecs[1] = '{16'h8000, 23'h400053};
        vecs[2] = '{16'h0001, 23'h000089};
        vecs[3] = '{16'h8001, 23'h4000DA};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // idle with in_valid low must not accept anything
        repeat (4) @(posedge CLK);
        #1;
        check("idle_no_accept_busy", 32'(busy), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, code, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
            check($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].code));
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_valid_drop", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_ready_back", i), 32'(in_ready), 32'd1);
        end

        // stall in DONE with a second word pending at the input
        out_ready = 1'b0;
        send(16'hA5C3, code_a, lat);
        check("stall_latency", 32'(lat), 32'd16);
        check("stall_code", 32'(code_a), 32'(ref_code(16'hA5C3)));
        b_word   = 16'h3C5A;
        in_valid = 1'b1;
        in_data  = b_word;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_code_hold", 32'(out_code), 32'(code_a));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("stall_release_idle", 32'(in_ready), 32'd1);
        check("stall_release_valid", 32'(out_valid), 32'd0);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        check("pending_accepted", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("pending_latency", 32'(lat), 32'd16);
        check("pending_code", 32'(out_code), 32'(ref_code(b_word)));
        @(posedge CLK);
        #1;

        // reset after five shifted bits aborts the word
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_code", 32'(out_code), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid || busy) lat++;
        end
        check("midrst_no_pulse", 32'(lat), 32'd0);

        // random words against the reference; every codeword must also divide cleanly
        for (int i = 0; i < 100; i++) begin
            d = 16'($urandom);
            send(d, code, lat);
            check("rand_latency", 32'(lat), 32'd16);
            check("rand_code", 32'(code), 32'(ref_code(d)));
            check("rand_data_field", 32'(code[22:7]), 32'(d));
            check("rand_syndrome", 32'(poly_mod(code)), 32'd0);
            @(posedge CLK);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
